// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch sequencer.
// Holds each fetched word until retirement, then fetches from next_pc.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0020,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        pc_advance,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [1:0]  err_code,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    ERR
  } state_e;

  localparam logic [7:0] TMO = TIMEOUT[7:0];

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        iv_q, iv_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  tmo_inc;
  logic        req_valid;

  assign tmo_inc = tmo_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    iv_d      = iv_q;
    err_d     = err_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    req_valid = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = WAIT;
          tmo_d   = '0;
        end
      end
      WAIT: begin
        tmo_d = tmo_inc;
        // A response in the final allowed cycle beats the timeout
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          iv_d    = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          state_d = HOLD;
        end else if (tmo_inc == TMO) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          state_d = ERR;
        end
      end
      HOLD: begin
        if (pc_advance) begin
          iv_d = 1'b0;
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = REQ;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = ERR;
          end
        end
      end
      ERR: iv_d = 1'b0;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      iv_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      iv_q    <= iv_d;
      err_q   <= err_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = iv_q;
  assign fetch_err      = err_q;
  assign err_code       = code_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.
// Request addresses and response words are tracked in scoreboard queues.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        pc_advance;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic [1:0]  err_code;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];

  pc_fetch_unit #(
    .RESET_PC(32'h0000_0020),
    .TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .next_pc       (next_pc),
    .pc_advance    (pc_advance),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .pc            (pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .fetch_err     (fetch_err),
    .err_code      (err_code),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h20);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_iv"}, {31'b0, instr_valid}, 32'h0);
    chk({tag, "_reqv"}, {31'b0, imem_req_valid}, 32'h0);
    chk({tag, "_err"}, {31'b0, fetch_err}, 32'h0);
    chk({tag, "_code"}, {30'b0, err_code}, 32'h0);
    chk({tag, "_cnt"}, fetch_count, 32'h0);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!imem_req_valid && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_reqseen"}, {31'b0, imem_req_valid}, 32'h1);
  endtask

  // Drive one request/response transaction and compare against scoreboard
  task automatic fetch(input string tag, input logic [31:0] data,
                       input int ready_lo, input int gap);
    logic [31:0] ea;
    logic [31:0] ed;
    wait_req(tag);
    ea = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_addr"}, imem_req_addr, ea);
    for (int i = 0; i < ready_lo; i++) step();
    if (ready_lo > 0) begin
      chk({tag, "_hold_v"}, {31'b0, imem_req_valid}, 32'h1);
      chk({tag, "_hold_a"}, imem_req_addr, ea);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk({tag, "_wait_v"}, {31'b0, imem_req_valid}, 32'h0);
    for (int i = 0; i < gap; i++) step();
    data_q.push_back(data);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    exp_cnt++;
    ed = data_q.pop_front();
    chk({tag, "_iv"}, {31'b0, instr_valid}, 32'h1);
    chk({tag, "_instr"}, instr, ed);
    chk({tag, "_cnt"}, fetch_count, exp_cnt);
  endtask

  task automatic advance(input logic [31:0] npc);
    pc_advance = 1'b1;
    next_pc    = npc;
    step();
    pc_advance = 1'b0;
    next_pc    = 32'h0;
    if (npc[1:0] == 2'b00) addr_q.push_back(npc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    step();
    step();
    rst_n = 1'b1;
    addr_q.delete();
    data_q.delete();
    addr_q.push_back(32'h20);
    exp_cnt = 0;
  endtask

  initial begin
    rst_n          = 1'b0;
    next_pc        = 32'h0;
    pc_advance     = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    step();
    step();
    chk_reset("rst");
    rst_n = 1'b1;
    addr_q.push_back(32'h20);
    chk("idle_reqv", {31'b0, imem_req_valid}, 32'h0);

    fetch("f1", 32'h0050_0093, 0, 0);
    chk("f1_pc", pc, 32'h20);

    advance(32'h24);
    chk("adv24_pc", pc, 32'h24);
    chk("adv24_iv", {31'b0, instr_valid}, 32'h0);
    fetch("f2", 32'h00a0_0113, 0, 0);
    advance(32'h58);
    chk("adv58_pc", pc, 32'h58);
    fetch("f3", 32'h0020_81b3, 0, 0);

    // Response pulse outside WAIT must not disturb the held word
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hFFFF_FFFF;
    step();
    imem_rsp_valid = 1'b0;
    chk("hold_rsp_instr", instr, 32'h0020_81b3);
    chk("hold_rsp_cnt", fetch_count, 32'd3);

    advance(32'h5C);
    fetch("f4", 32'h1111_0013, 5, 3);
    chk("f4_err", {31'b0, fetch_err}, 32'h0);

    advance(32'h60);
    fetch("f5", 32'h2222_0013, 0, 15);
    chk("f5_err", {31'b0, fetch_err}, 32'h0);

    advance(32'h64);
    wait_req("tmo");
    chk("tmo_addr", imem_req_addr, addr_q.pop_front());
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("tmo_pre_err", {31'b0, fetch_err}, 32'h0);
    step();
    chk("tmo_err", {31'b0, fetch_err}, 32'h1);
    chk("tmo_code", {30'b0, err_code}, 32'h2);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h3333_0013;
    step();
    imem_rsp_valid = 1'b0;
    step();
    chk("tmo_reqv", {31'b0, imem_req_valid}, 32'h0);
    chk("tmo_cnt", fetch_count, 32'd5);
    chk("tmo_iv", {31'b0, instr_valid}, 32'h0);
    chk("tmo_pc", pc, 32'h64);
    chk("tmo_sticky", {31'b0, fetch_err}, 32'h1);

    do_reset();
    fetch("m1", 32'h0050_0093, 0, 0);
    pc_advance = 1'b1;
    next_pc    = 32'h5A;
    step();
    pc_advance = 1'b0;
    chk("mis_err", {31'b0, fetch_err}, 32'h1);
    chk("mis_code", {30'b0, err_code}, 32'h1);
    chk("mis_pc", pc, 32'h20);
    chk("mis_iv", {31'b0, instr_valid}, 32'h0);
    step();
    step();
    chk("mis_reqv", {31'b0, imem_req_valid}, 32'h0);

    do_reset();
    wait_req("rw");
    chk("rw_addr", imem_req_addr, addr_q.pop_front());
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h4444_0013;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    chk_reset("rw");
    rst_n = 1'b1;
    addr_q.delete();
    data_q.delete();
    addr_q.push_back(32'h20);
    exp_cnt = 0;
    fetch("rw_f", 32'h5555_0013, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
